// File: rtl/dual_ram_pkg.sv
// rtl/dual_ram_pkg.sv - shared constants and types for the dual-port RAM arbiter
//
// Holds the default widths, the master id encoding, the legal read-latency
// range and the read-return tag carried down the latency pipeline.
package dual_ram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // One slot of the read-return pipeline: which master owns the read in flight.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/dual_ram_arbiter_rr_arb2.sv
// rtl/dual_ram_arbiter_rr_arb2.sv - two-requester round-robin arbiter with hold
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request from requester 0 / 1
//   hold       : suppresses the grant and the pointer update this cycle
//   gnt[1:0]   : one-hot (or zero) combinational grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  // Last-granted requester under contention; 1 after reset so requester 0
  // wins the first tie.
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (!hold) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // The pointer only moves when both requesters competed; a lone requester
  // does not disturb the fairness order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (!hold && req == 2'b11) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/dual_ram_arbiter.sv
// rtl/dual_ram_arbiter.sv - shares one dual-port RAM between two masters
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   m<n>_req/we/addr/wdata           : master n request (held until m<n>_gnt)
//   m<n>_gnt                         : master n accepted this cycle (combinational)
//   m<n>_rvalid/rdata                : master n read return (registered)
//   ram_cs                           : RAM chip select
//   ram_write_en/addr/data           : RAM write port
//   ram_read_en/addr, ram_read_data  : RAM read port
// RD_LAT must lie in RD_LAT_MIN..RD_LAT_MAX.
module dual_ram_arbiter
  import dual_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_cs,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_read_data
);

  logic [1:0] wr_req, rd_req, wr_gnt, rd_gnt;
  logic       rd_hold;
  rd_tag_t    tag_q [RD_LAT];
  rd_tag_t    tag_out;

  assign wr_req = {m1_req & m1_we, m0_req & m0_we};
  assign rd_req = {m1_req & ~m1_we, m0_req & ~m0_we};

  // A granted write comes from one master, so the only possible read
  // candidate is the other master; comparing against it avoids feeding the
  // read grant back into its own hold.
  assign rd_hold = (wr_gnt[0] & rd_req[1] & (m1_addr == m0_addr)) |
                   (wr_gnt[1] & rd_req[0] & (m0_addr == m1_addr));

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .hold  (1'b0),
    .gnt   (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .hold  (rd_hold),
    .gnt   (rd_gnt)
  );

  assign m0_gnt       = wr_gnt[0] | rd_gnt[0];
  assign m1_gnt       = wr_gnt[1] | rd_gnt[1];
  assign ram_write_en = |wr_gnt;
  assign ram_read_en  = |rd_gnt;
  assign ram_cs       = ram_write_en | ram_read_en;

  always_comb begin
    ram_write_addr = '0;
    ram_write_data = '0;
    ram_read_addr  = '0;
    if (wr_gnt[0]) begin
      ram_write_addr = m0_addr;
      ram_write_data = m0_wdata;
    end else if (wr_gnt[1]) begin
      ram_write_addr = m1_addr;
      ram_write_data = m1_wdata;
    end
    if (rd_gnt[0]) begin
      ram_read_addr = m0_addr;
    end else if (rd_gnt[1]) begin
      ram_read_addr = m1_addr;
    end
  end

  // Tag pipeline: the last stage lines up with valid RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: ram_read_en, id: rd_gnt[1]};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

  // Only the owning master's rdata is updated; the other keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= tag_out.valid && (tag_out.id == M0);
      m1_rvalid <= tag_out.valid && (tag_out.id == M1);
      if (tag_out.valid && tag_out.id == M0) m0_rdata <= ram_read_data;
      if (tag_out.valid && tag_out.id == M1) m1_rdata <= ram_read_data;
    end
  end

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// tb/tb_dual_ram_arbiter.sv - scoreboard bench for dual_ram_arbiter with a RAM model
module tb_dual_ram_arbiter;

  localparam int RD_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_cs, ram_write_en, ram_read_en;
  logic [7:0] ram_write_addr, ram_write_data, ram_read_addr, ram_read_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  logic [7:0] last0 = 8'd0;
  logic [7:0] last1 = 8'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req         (m0_req),
    .m0_we          (m0_we),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_gnt         (m0_gnt),
    .m0_rvalid      (m0_rvalid),
    .m0_rdata       (m0_rdata),
    .m1_req         (m1_req),
    .m1_we          (m1_we),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_gnt         (m1_gnt),
    .m1_rvalid      (m1_rvalid),
    .m1_rdata       (m1_rdata),
    .ram_cs         (ram_cs),
    .ram_write_en   (ram_write_en),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_read_en    (ram_read_en),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data)
  );

  // Dual-port RAM model: data visible RD_LAT cycles after the read enable.
  logic [7:0] mem [256] = '{default: 8'd0};
  logic [7:0] rd_pipe [RD_LAT] = '{default: 8'd0};

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
    if (ram_read_en) rd_pipe[0] <= mem[ram_read_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_read_data = rd_pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input logic id, input logic [7:0] data);
    sb.push_back('{id: id, data: data, due: cyc + RD_LAT + 1});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  // Read-return monitor: pops the scoreboard on every rvalid.
  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = 8'd0;
      last1 = 8'd0;
    end else if (m0_rvalid || m1_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {m1_rvalid, m0_rvalid}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rvalid_sel", {m1_rvalid, m0_rvalid}, e.id ? 2'b10 : 2'b01);
        check("rdata", e.id ? m1_rdata : m0_rdata, e.data);
        check("rvalid_cycle", cyc, e.due);
        check("other_rdata_hold", e.id ? m0_rdata : m1_rdata, e.id ? last0 : last1);
        if (e.id) last1 = e.data; else last0 = e.data;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {m0_gnt, m1_gnt, ram_cs, ram_write_en, ram_read_en, m0_rvalid, m1_rvalid}, 0);
    check("reset_rdata", {m0_rdata, m1_rdata}, 0);
    check("reset_addr_data", {ram_write_addr, ram_write_data, ram_read_addr}, 0);

    // Single master write then read back.
    next_cycle();
    rst_n = 1'b1;
    drive(1, 1, 8'd1, 8'd100, 0, 0, 0, 0);
    @(negedge clk);
    check("m0_wr_gnt", m0_gnt, 1);
    check("m0_wr_port", {ram_write_en, ram_write_addr, ram_write_data}, {1'b1, 8'd1, 8'd100});
    next_cycle();
    drive(1, 0, 8'd1, 8'd0, 0, 0, 0, 0);
    @(negedge clk);
    check("m0_rd_gnt", m0_gnt, 1);
    check("m0_rd_port", {ram_read_en, ram_read_addr, ram_write_en}, {1'b1, 8'd1, 1'b0});
    expect_read(1'b0, 8'd100);

    // Write contention alternates starting with M0.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive(1, 1, 8'd2, 8'd101, 1, 1, 8'd3, 8'd102);
      @(negedge clk);
      check("wr_alt_gnt", {m1_gnt, m0_gnt}, (k % 2) ? 2'b10 : 2'b01);
      check("wr_alt_port", {ram_write_addr, ram_write_data},
            (k % 2) ? {8'd3, 8'd102} : {8'd2, 8'd101});
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("mem2", mem[2], 101);
    check("mem3", mem[3], 102);

    // Concurrent write and read at different addresses.
    drive(1, 1, 8'd5, 8'd55, 1, 0, 8'd6, 8'd0);
    @(negedge clk);
    check("wr_rd_gnt", {m0_gnt, m1_gnt, ram_cs, ram_write_en, ram_read_en}, 5'b11111);
    check("wr_rd_raddr", ram_read_addr, 6);
    expect_read(1'b1, 8'd0);

    // Same-address collision: read stalls one cycle and sees the new data.
    next_cycle();
    drive(1, 1, 8'd7, 8'd77, 1, 0, 8'd7, 8'd0);
    @(negedge clk);
    check("coll_stall", {m0_gnt, m1_gnt, ram_read_en}, 3'b100);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 8'd7, 8'd0);
    @(negedge clk);
    check("coll_retry", {m1_gnt, ram_read_en, ram_read_addr}, {1'b1, 1'b1, 8'd7});
    expect_read(1'b1, 8'd77);

    // Read contention: M0 first, then M1.
    next_cycle();
    drive(1, 0, 8'd3, 8'd0, 1, 0, 8'd2, 8'd0);
    @(negedge clk);
    check("rd_cont_gnt", {m1_gnt, m0_gnt}, 2'b01);
    expect_read(1'b0, 8'd102);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 8'd2, 8'd0);
    @(negedge clk);
    check("rd_cont_gnt2", {m1_gnt, m0_gnt}, 2'b10);
    expect_read(1'b1, 8'd101);

    // Interleaved single reads on consecutive cycles.
    next_cycle();
    drive(1, 0, 8'd1, 8'd0, 0, 0, 0, 0);
    @(negedge clk);
    check("intl_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
    expect_read(1'b0, 8'd100);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 8'd2, 8'd0);
    @(negedge clk);
    check("intl_m1_gnt", {m1_gnt, m0_gnt}, 2'b10);
    expect_read(1'b1, 8'd101);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drain();

    // Move the write pointer so M1 would win without a reset.
    next_cycle();
    drive(1, 1, 8'd10, 8'd1, 1, 1, 8'd11, 8'd2);
    @(negedge clk);
    check("pre_rst_cont", {m1_gnt, m0_gnt}, 2'b01);

    // Reset with a read in flight.
    next_cycle();
    drive(1, 0, 8'd1, 8'd0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_rd_gnt", m0_gnt, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    end
    next_cycle();
    drive(1, 1, 8'd8, 8'd3, 1, 1, 8'd9, 8'd4);
    @(negedge clk);
    check("post_rst_cont", {m1_gnt, m0_gnt}, 2'b01);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("sb_empty_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
